// File: rtl/micro_op_issue.sv
// Micro-op issue stage: RAW scoreboard, operand resolve, dispatch.
// Optional ISSUE_WB_BYPASS_EN: issue on the writeback cycle using wb_data.
package micro_op_pkg;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_ZERO = 2'd1,
    OP1_PC   = 2'd2
  } op1_src_e;

  typedef enum logic {
    OP2_RS2 = 1'b0,
    OP2_IMM = 1'b1
  } op2_src_e;

  typedef enum logic {
    CSR_REG = 1'b0,
    CSR_IMM = 1'b1
  } csr_src_e;

  typedef struct packed {
    logic     en;
    logic [3:0] op;
    op1_src_e op1_src;
    op2_src_e op2_src;
  } alu_t;

  typedef struct packed {
    logic       en;
    logic [2:0] op;
  } br_t;

  typedef struct packed {
    logic       en;
    logic       store;
    logic [1:0] size;
  } ld_st_t;

  typedef struct packed {
    logic       en;
    csr_src_e   rs1_src;
    logic [1:0] op;
  } csr_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rd_en;
    alu_t        alu;
    br_t         br_unit;
    ld_st_t      ld_st_unit;
    csr_t        csr_unit;
  } MicroCode;

endpackage

module micro_op_issue
  import micro_op_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  MicroCode    in_uop,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output MicroCode    out_uop,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [31:0] out_rs2_data,
  output logic [31:0] busy_mask
);

  localparam logic [PEND_W-1:0] PMAX = {PEND_W{1'b1}};

  logic [PEND_W-1:0] pend_q [32];
  logic [PEND_W-1:0] pend_d [32];
  logic              valid_q, valid_d;
  MicroCode          uop_q, uop_d;
  logic [31:0]       op1_q, op1_d;
  logic [31:0]       op2_q, op2_d;
  logic [31:0]       rs2d_q, rs2d_d;

  logic        rs1_use, rs2_use;
  logic        rs1_byp, rs2_byp;
  logic        rs1_haz, rs2_haz, rd_haz;
  logic        hazard, fire;
  logic [31:0] rs1_val, rs2_val;

  assign rf_rs1_addr = in_uop.rs1_addr;
  assign rf_rs2_addr = in_uop.rs2_addr;

  assign rs1_use =
    (in_uop.alu.en && in_uop.alu.op1_src == OP1_RS1) ||
    in_uop.br_unit.en || in_uop.ld_st_unit.en ||
    (in_uop.csr_unit.en && in_uop.csr_unit.rs1_src == CSR_REG);

  assign rs2_use =
    (in_uop.alu.en && in_uop.alu.op2_src == OP2_RS2) ||
    in_uop.br_unit.en ||
    (in_uop.ld_st_unit.en && in_uop.ld_st_unit.store);

`ifdef ISSUE_WB_BYPASS_EN
  // Last outstanding write retiring now: take its value directly.
  assign rs1_byp = wb_valid && wb_addr == in_uop.rs1_addr &&
                   in_uop.rs1_addr != 5'd0 &&
                   pend_q[in_uop.rs1_addr] == PEND_W'(1);
  assign rs2_byp = wb_valid && wb_addr == in_uop.rs2_addr &&
                   in_uop.rs2_addr != 5'd0 &&
                   pend_q[in_uop.rs2_addr] == PEND_W'(1);
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  assign rs1_val = rs1_byp ? wb_data : rf_rs1_data;
  assign rs2_val = rs2_byp ? wb_data : rf_rs2_data;

  assign rs1_haz = rs1_use && in_uop.rs1_addr != 5'd0 &&
                   pend_q[in_uop.rs1_addr] != '0 && !rs1_byp;
  assign rs2_haz = rs2_use && in_uop.rs2_addr != 5'd0 &&
                   pend_q[in_uop.rs2_addr] != '0 && !rs2_byp;
  assign rd_haz  = in_uop.rd_en && in_uop.rd_addr != 5'd0 &&
                   pend_q[in_uop.rd_addr] == PMAX;

  assign hazard   = rs1_haz || rs2_haz || rd_haz;
  assign in_ready = !flush && !hazard && (!valid_q || out_ready);
  assign fire     = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    uop_d   = uop_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    rs2d_d  = rs2d_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (fire) begin
      valid_d = 1'b1;
      uop_d   = in_uop;
      rs2d_d  = rs2_val;
      op1_d   = '0;
      unique case (1'b1)
        (in_uop.alu.op1_src == OP1_RS1): op1_d = rs1_val;
        (in_uop.alu.op1_src == OP1_PC):  op1_d = in_uop.pc;
        default:                         op1_d = '0;
      endcase
      op2_d = (in_uop.alu.op2_src == OP2_IMM) ?
              in_uop.imm_data : rs2_val;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Up to two decrements (writeback + flushed uop) may hit one reg.
  always_comb begin
    logic              inc, dwb, dfl;
    logic [1:0]        nd;
    logic [PEND_W+1:0] p, n;
    inc = 1'b0;
    dwb = 1'b0;
    dfl = 1'b0;
    nd  = '0;
    p   = '0;
    n   = '0;
    pend_d[0] = '0;
    for (int i = 1; i < 32; i++) begin
      inc = fire && in_uop.rd_en && in_uop.rd_addr == 5'(i);
      dwb = wb_valid && wb_addr == 5'(i);
      dfl = flush && valid_q && uop_q.rd_en &&
            uop_q.rd_addr == 5'(i);
      nd  = 2'(dwb) + 2'(dfl);
      p   = {2'b00, pend_q[i]};
      if (inc && nd == 2'd0) begin
        pend_d[i] = pend_q[i] + PEND_W'(1);
      end else begin
        if (inc) nd = nd - 2'd1;
        n = (PEND_W+2)'(nd);
        pend_d[i] = (n >= p) ? '0 : PEND_W'(p - n);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      uop_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      rs2d_q  <= '0;
      for (int i = 0; i < 32; i++) pend_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      uop_q   <= uop_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rs2d_q  <= rs2d_d;
      for (int i = 0; i < 32; i++) pend_q[i] <= pend_d[i];
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 1; i < 32; i++) busy_mask[i] = pend_q[i] != '0;
  end

  assign out_valid    = valid_q;
  assign out_uop      = uop_q;
  assign out_op1      = op1_q;
  assign out_op2      = op2_q;
  assign out_rs2_data = rs2d_q;

  a_wb_underflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(wb_valid && wb_addr != 5'd0 && pend_q[wb_addr] == '0)
  );

endmodule

// File: tb/tb_micro_op_issue.sv
// Directed bench for micro_op_issue with a behavioural register file.
// Expectations follow ISSUE_WB_BYPASS_EN when it is defined.
module tb_micro_op_issue;
  import micro_op_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  MicroCode    in_uop;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  MicroCode    out_uop;
  logic [31:0] out_op1, out_op2, out_rs2_data, busy_mask;

  logic [31:0] rf [32];
  int n_chk  = 0;
  int n_fail = 0;

  micro_op_issue #(.PEND_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_uop       (in_uop),
    .rf_rs1_addr  (rf_rs1_addr),
    .rf_rs2_addr  (rf_rs2_addr),
    .rf_rs1_data  (rf_rs1_data),
    .rf_rs2_data  (rf_rs2_data),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_uop      (out_uop),
    .out_op1      (out_op1),
    .out_op2      (out_op2),
    .out_rs2_data (out_rs2_data),
    .busy_mask    (busy_mask)
  );

  always #5 clk = ~clk;

  assign rf_rs1_data = (rf_rs1_addr == 5'd0) ? 32'd0 : rf[rf_rs1_addr];
  assign rf_rs2_data = (rf_rs2_addr == 5'd0) ? 32'd0 : rf[rf_rs2_addr];

  always @(posedge clk)
    if (wb_valid && wb_addr != 5'd0) rf[wb_addr] <= wb_data;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
  endtask

  function automatic MicroCode addi(input logic [4:0] rd,
                                    input logic [4:0] rs1,
                                    input logic [31:0] imm);
    MicroCode u;
    u = '0;
    u.alu.en = 1'b1;
    u.alu.op1_src = OP1_RS1;
    u.alu.op2_src = OP2_IMM;
    u.rs1_addr = rs1;
    u.rd_addr = rd;
    u.rd_en = 1'b1;
    u.imm_data = imm;
    return u;
  endfunction

  function automatic MicroCode add(input logic [4:0] rd,
                                   input logic [4:0] rs1,
                                   input logic [4:0] rs2);
    MicroCode u;
    u = addi(rd, rs1, 32'd0);
    u.alu.op2_src = OP2_RS2;
    u.rs2_addr = rs2;
    return u;
  endfunction

  function automatic MicroCode lui(input logic [4:0] rd,
                                   input logic [31:0] imm);
    MicroCode u;
    u = addi(rd, 5'd0, imm);
    u.alu.op1_src = OP1_ZERO;
    return u;
  endfunction

  function automatic MicroCode auipc(input logic [4:0] rd,
                                     input logic [31:0] pc,
                                     input logic [31:0] imm);
    MicroCode u;
    u = addi(rd, 5'd0, imm);
    u.alu.op1_src = OP1_PC;
    u.pc = pc;
    return u;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_uop = '0;
    wb_valid = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_op1", out_op1, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("idle_ready", 32'(in_ready), 32'd1);
    tick();

    // RAW on x1
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_uop = addi(5'd1, 5'd0, 32'd5);
    #1;
    chk("addi_ready", 32'(in_ready), 32'd1);
    tick();
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_op2", out_op2, 32'd5);
    chk("addi_busy", busy_mask, 32'h2);
    in_uop = add(5'd2, 5'd1, 5'd1);
    #1;
    chk("raw_stall", 32'(in_ready), 32'd0);
    tick();
    wb(5'd1, 32'd5);
    #1;
`ifdef ISSUE_WB_BYPASS_EN
    chk("byp_ready", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
`else
    chk("nobyp_stall", 32'(in_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("rf_ready", 32'(in_ready), 32'd1);
    tick();
`endif
    chk("add_op1", out_op1, 32'd5);
    chk("add_op2", out_op2, 32'd5);
    chk("add_rs2d", out_rs2_data, 32'd5);
    chk("add_busy", busy_mask, 32'h4);

    // backpressure
    out_ready = 1'b0;
    in_uop = addi(5'd6, 5'd0, 32'd7);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("hold_op1", out_op1, 32'd5);
      chk("hold_rd", 32'(out_uop.rd_addr), 32'd2);
      chk("hold_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("release_rd", 32'(out_uop.rd_addr), 32'd6);
    chk("release_op2", out_op2, 32'd7);
    chk("release_busy", busy_mask, 32'h44);
    in_valid = 1'b0;
    wb(5'd2, 32'd10);
    tick();
    wb(5'd6, 32'd7);
    tick();
    wb_valid = 1'b0;
    chk("drain_busy", busy_mask, 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // flush
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_uop = addi(5'd3, 5'd0, 32'd9);
    tick();
    chk("fl_pre_valid", 32'(out_valid), 32'd1);
    chk("fl_pre_busy", busy_mask, 32'h8);
    in_uop = addi(5'd7, 5'd0, 32'd1);
    flush = 1'b1;
    #1;
    chk("fl_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_busy", busy_mask, 32'd0);

    // pending counter saturation on x4
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_uop = addi(5'd4, 5'd0, 32'd1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("sat_ready", 32'(in_ready), 32'd1);
      tick();
    end
    #1;
    chk("sat_busy", busy_mask, 32'h10);
    chk("sat_stall", 32'(in_ready), 32'd0);
    tick();
    wb(5'd4, 32'd1);
    #1;
    chk("sat_wb_stall", 32'(in_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("sat_after_wb", 32'(in_ready), 32'd1);
    tick();
    chk("sat4_valid", 32'(out_valid), 32'd1);
    chk("sat4_rd", 32'(out_uop.rd_addr), 32'd4);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wb(5'd4, 32'd1);
      tick();
    end
    wb_valid = 1'b0;
    chk("sat_clear", busy_mask, 32'd0);

    // operand sources and x0 destination
    in_valid = 1'b1;
    in_uop = lui(5'd5, 32'h1234_5000);
    tick();
    chk("lui_op1", out_op1, 32'd0);
    chk("lui_op2", out_op2, 32'h1234_5000);
    in_uop = auipc(5'd8, 32'h100, 32'h1000);
    tick();
    chk("auipc_op1", out_op1, 32'h100);
    chk("auipc_op2", out_op2, 32'h1000);
    in_uop = addi(5'd0, 5'd0, 32'd3);
    tick();
    chk("x0_valid", 32'(out_valid), 32'd1);
    chk("x0_busy", busy_mask, 32'h120);
    in_valid = 1'b0;
    wb(5'd5, 32'h1234_5000);
    tick();
    wb(5'd8, 32'h1100);
    tick();
    wb_valid = 1'b0;
    chk("final_busy", busy_mask, 32'd0);
    chk("final_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
